// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-speed controller: state encoding,
// event encoding, default period constants and the level-width helper.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Only the highest-priority event of a cycle survives arbitration.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_OVER,
    EV_START,
    EV_PAUSE,
    EV_SPEED
  } event_t;

  localparam int          DEF_WIDTH       = 20;
  localparam int          DEF_LEVELS      = 8;
  localparam logic [19:0] DEF_BASE_PERIOD = 20'd999_999;
  localparam logic [19:0] DEF_STEP        = 20'd100_000;
  localparam logic [19:0] DEF_MIN_PERIOD  = 20'd199_999;

  function automatic int level_width(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

endpackage

// File: rtl/snake_tick_scheduler_period_counter.sv
// Free-running period counter: counts while enabled, wraps to zero once the
// count reaches or passes the programmed period, and registers a wrap pulse.
module period_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  // The >= compare lets a period that shrank below the current count wrap at once.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      if (count >= period) begin
        count <= '0;
        wrap  <= 1'b1;
      end else begin
        count <= count + WIDTH'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/snake_tick_scheduler.sv
// Game-speed controller: sequences IDLE/RUN/PAUSE/OVER, maps the speed level
// to a counter wrap value and emits a one-cycle movement tick.
module snake_tick_scheduler
  import snake_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               LEVELS      = DEF_LEVELS,
  parameter logic [WIDTH-1:0] BASE_PERIOD = WIDTH'(DEF_BASE_PERIOD),
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(DEF_STEP),
  parameter logic [WIDTH-1:0] MIN_PERIOD  = WIDTH'(DEF_MIN_PERIOD),
  localparam int              LW          = level_width(LEVELS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             speed_up,
  input  logic             game_over,
  output logic             tick,
  output logic [1:0]       state,
  output logic [LW-1:0]    level,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count
);

  localparam int XW = WIDTH + LW;

  state_t         state_q;
  state_t         state_d;
  event_t         ev;
  logic           do_start;
  logic           do_speed;
  logic           wrap;
  logic [XW-1:0]  base_x;
  logic [XW-1:0]  min_x;
  logic [XW-1:0]  prod_x;
  logic [XW-1:0]  period_x;
  logic [WIDTH-1:0] period_calc;

  always_comb begin
    ev = EV_NONE;
    if (game_over)     ev = EV_OVER;
    else if (start)    ev = EV_START;
    else if (pause)    ev = EV_PAUSE;
    else if (speed_up) ev = EV_SPEED;
  end

  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    do_speed = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (ev == EV_START) begin
          state_d  = RUN;
          do_start = 1'b1;
        end
      end
      RUN: begin
        case (ev)
          EV_OVER:  state_d  = OVER;
          EV_PAUSE: state_d  = PAUSE;
          EV_SPEED: do_speed = 1'b1;
          default:  ;
        endcase
      end
      PAUSE: begin
        if (ev == EV_OVER)       state_d = OVER;
        else if (ev == EV_PAUSE) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset || do_start) begin
      level <= '0;
    end else if (do_speed && (level != LW'(LEVELS - 1))) begin
      level <= level + LW'(1);
    end
  end

  // Widened arithmetic so a large level*STEP cannot underflow before the clamp.
  always_comb begin
    base_x   = XW'(BASE_PERIOD);
    min_x    = XW'(MIN_PERIOD);
    prod_x   = XW'(level) * XW'(STEP);
    period_x = min_x;
    if ((prod_x <= base_x) && ((base_x - prod_x) >= min_x)) begin
      period_x = base_x - prod_x;
    end
  end

  assign period_calc = WIDTH'(period_x);

  always_ff @(posedge clock) begin
    if (reset || do_start) period <= BASE_PERIOD;
    else                   period <= period_calc;
  end

  // Counting tracks the state being entered, so a pause freezes the count
  // on the same edge it is accepted and a resume counts immediately.
  period_counter #(
    .WIDTH (WIDTH)
  ) u_period_counter (
    .clock  (clock),
    .reset  (reset),
    .en     (state_d == RUN),
    .clr    (do_start),
    .period (period),
    .count  (count),
    .wrap   (wrap)
  );

  assign tick  = wrap && (state_q != OVER);
  assign state = state_q;

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// Bench for snake_tick_scheduler: directed scenarios with literal expectations
// plus randomized events, all outputs compared to a behavioural game model.
module tb_snake_tick_scheduler;

  localparam int BASE   = 4;
  localparam int STP    = 1;
  localparam int MINP   = 2;
  localparam int LEVELS = 4;

  logic        clock;
  logic        reset;
  logic        start;
  logic        pause;
  logic        speed_up;
  logic        game_over;
  logic        tick;
  logic [1:0]  state;
  logic [1:0]  level;
  logic [19:0] period;
  logic [19:0] count;

  int errors = 0;
  int checks = 0;

  snake_tick_scheduler #(
    .WIDTH       (20),
    .LEVELS      (LEVELS),
    .BASE_PERIOD (20'(BASE)),
    .STEP        (20'(STP)),
    .MIN_PERIOD  (20'(MINP))
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .speed_up  (speed_up),
    .game_over (game_over),
    .tick      (tick),
    .state     (state),
    .level     (level),
    .period    (period),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural model ----------------
  int m_state, m_level, m_period, m_count, m_tick;
  int m_next, m_old_level;
  bit m_start, m_valid = 1'b0;

  function automatic int model_period(input int lvl);
    int p;
    p = BASE - lvl * STP;
    if (p < MINP) p = MINP;
    return p;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_state = 0; m_level = 0; m_period = BASE; m_count = 0; m_tick = 0;
      m_valid = 1'b1;
    end else begin
      m_next = m_state;
      m_start = 1'b0;
      m_old_level = m_level;
      if (game_over) begin
        if (m_state == 1 || m_state == 2) m_next = 3;
      end else if (start) begin
        if (m_state == 0 || m_state == 3) begin m_next = 1; m_start = 1'b1; end
      end else if (pause) begin
        if (m_state == 1) m_next = 2;
        else if (m_state == 2) m_next = 1;
      end else if (speed_up) begin
        if (m_state == 1 && m_level < LEVELS - 1) m_level = m_level + 1;
      end
      if (m_start) begin
        m_level = 0; m_period = BASE; m_count = 0; m_tick = 0;
      end else begin
        if (m_next == 1) begin
          if (m_count >= m_period) begin m_count = 0; m_tick = 1; end
          else begin m_count = m_count + 1; m_tick = 0; end
        end else begin
          m_tick = 0;
        end
        m_period = model_period(m_old_level);
      end
      m_state = m_next;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_state",  32'(state),  32'(m_state));
      check("model_level",  32'(level),  32'(m_level));
      check("model_period", 32'(period), 32'(m_period));
      check("model_count",  32'(count),  32'(m_count));
      check("model_tick",   32'(tick),   32'(m_tick));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input bit s, input bit p, input bit su, input bit g);
    start = s; pause = p; speed_up = su; game_over = g;
    cyc();
    start = 1'b0; pause = 1'b0; speed_up = 1'b0; game_over = 1'b0;
  endtask

  task automatic run_until_count(input int target, input string name);
    for (int i = 0; i < 12 && count != 20'(target); i++) cyc();
    check(name, 32'(count), 32'(target));
  endtask

  int tick_seen;
  int t_first, t_second;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; speed_up = 1'b0; game_over = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check("reset_state", 32'(state), 0);
    check("reset_level", 32'(level), 0);
    check("reset_period", 32'(period), 4);
    check("reset_count", 32'(count), 0);
    check("reset_tick", 32'(tick), 0);

    tick_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      if (tick) tick_seen++;
    end
    check("idle_no_tick", 32'(tick_seen), 0);
    check("idle_state", 32'(state), 0);

    // start: count 0,1,2,3,4,0 with a tick on the wrap
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_state", 32'(state), 1);
    check("start_count", 32'(count), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("run_count_seq", 32'(count), 32'(i % 5));
      check("run_tick_seq", 32'(tick), (i == 5) ? 32'd1 : 32'd0);
    end

    // speed-ups: level 1,2,3,3 and period 3,2,2,2 one cycle later
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check("speed_level", 32'(level), (i < 3) ? 32'(i) : 32'd3);
      cyc();
      check("speed_period", 32'(period), (i == 1) ? 32'd3 : 32'd2);
    end
    t_first = -1; t_second = -1;
    for (int i = 0; i < 20 && t_second < 0; i++) begin
      cyc();
      if (tick) begin
        if (t_first < 0) t_first = i;
        else t_second = i;
      end
    end
    check("fast_tick_interval", 32'(t_second - t_first), 3);

    // speed-up exactly on the wrap cycle: one tick only
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("over_state", 32'(state), 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run_until_count(4, "wrap_setup");
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_count", 32'(count), 0);
    check("wrap_tick", 32'(tick), 1);
    check("wrap_level", 32'(level), 1);
    cyc();
    check("wrap_no_double", 32'(tick), 0);
    check("wrap_new_period", 32'(period), 3);
    cyc();
    check("wrap_no_double2", 32'(tick), 0);

    // pause at count 2 for 7 cycles
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run_until_count(2, "pause_setup");
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_state", 32'(state), 2);
    check("pause_count", 32'(count), 2);
    tick_seen = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check("pause_hold", 32'(count), 2);
      if (tick) tick_seen++;
    end
    check("pause_no_tick", 32'(tick_seen), 0);
    check("pause_level_held", 32'(level), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("resume_state", 32'(state), 1);
    check("resume_tick0", 32'(tick), 0);
    cyc();
    check("resume_tick1", 32'(tick), 0);
    cyc();
    check("resume_tick2", 32'(tick), 1);

    // same-cycle events, restart, mid-run reset
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("combo_pre_level", 32'(level), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("combo_state", 32'(state), 3);
    check("combo_level", 32'(level), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("over_ignores", 32'(state), 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_level", 32'(level), 0);
    check("restart_count", 32'(count), 0);
    check("restart_period", 32'(period), 4);
    repeat (3) cyc();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("midreset_state", 32'(state), 0);
    check("midreset_count", 32'(count), 0);
    check("midreset_period", 32'(period), 4);
    check("midreset_tick", 32'(tick), 0);
    reset = 1'b0;

    // randomized events, checked every cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 999) < 3);
      start     = ($urandom_range(0, 99) < 4);
      pause     = ($urandom_range(0, 99) < 5);
      speed_up  = ($urandom_range(0, 99) < 6);
      game_over = ($urandom_range(0, 99) < 2);
      cyc();
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0; speed_up = 1'b0; game_over = 1'b0;
    cyc();
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_tick_scheduler.md
# snake_tick_scheduler

Game-speed controller for the snake datapath. It owns the 20-bit period counter and sequences it through idle/run/pause/over states. It programs the counter's wrap value from a speed level and emits a single-cycle `tick` that advances snake movement. It sits between the input/game-logic FSM (which issues start, pause, speed-up and game-over events) and the movement/display logic (which consumes `tick`).

## Interface
Parameters:
- `WIDTH`, 20: counter and period width.
- `LEVELS`, 8: number of speed levels. Power of two; `level` width is log2(LEVELS).
- `BASE_PERIOD`, 20'd999_999: wrap value at level 0.
- `STEP`, 20'd100_000: period reduction per level.
- `MIN_PERIOD`, 20'd199_999: floor for the period.

Ports:
- `clock`  in  1: single system clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: pulse; begin a new game from IDLE or OVER.
- `pause`  in  1: pulse; toggles RUN↔PAUSE.
- `speed_up`  in  1: pulse; raise the speed level by one.
- `game_over`  in  1: pulse; end the game.
- `tick`  out  1: one-cycle movement strobe.
- `state`  out  2: IDLE=0, RUN=1, PAUSE=2, OVER=3.
- `level`  out  log2(LEVELS): current speed level.
- `period`  out  WIDTH: active wrap value.
- `count`  out  WIDTH: current counter value.

## Operation
- Reset values: `state`=IDLE, `level`=0, `period`=BASE_PERIOD, `count`=0, `tick`=0.
- Event priority within one cycle: game_over > start > pause > speed_up. Lower-priority events in the same cycle are dropped.
- State transitions:
  - IDLE: `start` → RUN. All other events are ignored.
  - RUN: `game_over` → OVER; `pause` → PAUSE; `speed_up` stays in RUN and increments level.
  - PAUSE: `game_over` → OVER; `pause` → RUN. `speed_up` is ignored.
  - OVER: `start` → RUN. All other events are ignored.
- On `start`: `level`←0, `period`←BASE_PERIOD, `count`←0.
- Counter:
  - Increments only in RUN.
  - When `count >= period`, the next value is `count`←0 and `tick`←1. Otherwise `tick`←0.
  - Holds its value in PAUSE and OVER.
  - Cleared on entry to RUN from IDLE/OVER. Not cleared on resume from PAUSE.
- Level and period:
  - `level` saturates at LEVELS-1; a `speed_up` at max level is a no-op.
  - `period` = max(BASE_PERIOD − level·STEP, MIN_PERIOD).
  - Compute the period at WIDTH+log2(LEVELS) bits to avoid underflow before clamping.
  - `period` is registered and updates the cycle after `level` changes.
- A shortened period below the current `count` wraps on the next RUN cycle via the `>=` compare. At most one tick is produced per wrap.
- `tick` is never asserted outside RUN, except in the single cycle immediately after a transition out of RUN, because it is registered. It is forced to 0 when `state` is OVER.
- `reset` asserted mid-game returns every output to its reset value on the next edge, regardless of pending events.

## Timing
- Event sampled at edge N → `state`/`level` reflect it after edge N; `period` reflects a level change after edge N+1.
- `start` at edge N → `count`=0 after edge N; first `tick` high in the cycle after edge N+period+1, i.e. period+1 RUN cycles per tick.
- Steady RUN: `tick` period is exactly `period`+1 cycles; `tick` is high for 1 cycle.
- Pause/resume: ticks are delayed by exactly the number of PAUSE cycles; the counter phase is preserved.

## Structure
- Shared package `snake_pkg`: state encoding constants (IDLE/RUN/PAUSE/OVER), the default WIDTH/period constants, and the `level` width function.
- One sub-module, `period_counter`:
  - Holds the WIDTH-bit counter with `en`, `clr` and `>=`-wrap against an external `period`.
  - Outputs `count` and the registered `wrap` pulse.
- Top level: FSM, level/period registers, instance of `period_counter`.

## Test plan
Bench parameters: BASE_PERIOD=4, STEP=1, MIN_PERIOD=2, LEVELS=4.
- Reset held 3 cycles, then released → `state`=0, `level`=0, `period`=4, `count`=0, `tick`=0. No tick for 20 idle cycles.
- `start` pulse → `state`=1; `tick` every 5 cycles, first one 5 cycles after start; `count` sequence 0,1,2,3,4,0.
- `speed_up` ×3 in RUN, then a 4th → `level` 1,2,3,3; `period` 3,2,2,2, clamped. Tick interval becomes 3 cycles.
- `speed_up` asserted while `count`=4 and old period=4 → `count` wraps on the next RUN cycle. Exactly one tick, no double tick.
- `pause` at `count`=2, hold 7 cycles, then `pause` → `count` stays 2 during PAUSE, no ticks; the next tick arrives 3 cycles after resume.
- Same-cycle `game_over`+`pause`+`speed_up` → `state`=3 and `level` unchanged. Then `start` → `level`=0, `count`=0. `reset` mid-RUN → all reset values on the next edge.
